// File: rtl/fft_pkg.sv
// Shared definitions for the FFT capture path: bank and fill-FSM encodings
// plus a width-generic bit-reverse helper.
package fft_pkg;

    localparam int LOG2_N_DEFAULT = 10;
    localparam int MAX_LOG2_N     = 12;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    typedef enum logic {
        FILL,
        WAIT_BANK
    } fill_state_t;

    // Mirrors the low 'width' bits of value; anything above width comes back zero.
    function automatic logic [MAX_LOG2_N-1:0] bit_reverse(input logic [MAX_LOG2_N-1:0] value,
                                                          input int                    width);
        logic [MAX_LOG2_N-1:0] rev;
        rev = {<<{value}};
        return rev >> (MAX_LOG2_N - width);
    endfunction

endpackage

// File: rtl/bitrev_addr_gen.sv
// Per-frame sample counter with a mode latched on the first sample and a
// registered write address in either bit-reversed or natural order.
module bitrev_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_N = LOG2_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic              mode_in,
    output logic [LOG2_N-1:0] count,
    output logic [LOG2_N-1:0] addr,
    output logic              mode,
    output logic              last
);

    logic                  mode_eff;
    logic [LOG2_N-1:0]     addr_next;
    logic [MAX_LOG2_N-1:0] count_wide;
    logic [MAX_LOG2_N-1:0] count_rev;

    assign last     = (count == {LOG2_N{1'b1}});
    assign mode_eff = (count == '0) ? mode_in : mode;

    always_comb begin
        count_wide              = '0;
        count_wide[LOG2_N-1:0] = count;
        count_rev               = bit_reverse(count_wide, LOG2_N);
        addr_next               = mode_eff ? count_rev[LOG2_N-1:0] : count;
    end

    // The counter wraps to zero naturally after the last sample of a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            addr  <= '0;
            mode  <= 1'b0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
            addr  <= addr_next;
            mode  <= mode_eff;
        end
    end

endmodule

// File: rtl/bitrev_frame_loader.sv
// Ping-pong FFT input loader: writes a sample stream into two banks and hands
// completed frames to the FFT over a two-deep valid/ack presentation queue.
module bitrev_frame_loader
    import fft_pkg::*;
#(
    parameter int LOG2_N       = LOG2_N_DEFAULT,
    parameter int DATA_W       = 16,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              bitrev_en,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic              mem_bank,
    output logic [LOG2_N-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              frame_valid,
    output logic              frame_bank,
    output logic              frame_bitrev,
    input  logic              frame_ack,
    output logic [LOG2_N-1:0] count,
    output logic [15:0]       drop_cnt
);

    fill_state_t state_q, state_d;
    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        fill_bank_q, fill_bank_d;
    logic        q_bank_q [2];
    logic        q_bank_d [2];
    logic        q_mode_q [2];
    logic        q_mode_d [2];
    logic [1:0]  q_cnt_q, q_cnt_d;
    logic        accept, pop, last, frame_mode, other;

    assign s_ready      = (state_q == FILL) || DROP_ON_FULL;
    assign accept       = s_valid && (state_q == FILL) && !clr;
    assign pop          = frame_ack && (q_cnt_q != 2'd0);
    assign other        = ~fill_bank_q;
    assign frame_valid  = (q_cnt_q != 2'd0);
    assign frame_bank   = q_bank_q[0];
    assign frame_bitrev = q_mode_q[0];

    bitrev_addr_gen #(
        .LOG2_N (LOG2_N)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr && (state_q == FILL)),
        .inc     (accept),
        .mode_in (bitrev_en),
        .count   (count),
        .addr    (mem_addr),
        .mode    (frame_mode),
        .last    (last)
    );

    // The pop is applied first so a bank freed this cycle can be reused at once.
    always_comb begin
        state_d     = state_q;
        fill_bank_d = fill_bank_q;
        bank_d      = bank_q;
        q_bank_d    = q_bank_q;
        q_mode_d    = q_mode_q;
        q_cnt_d     = q_cnt_q;

        if (pop) begin
            bank_d[q_bank_q[0]] = BANK_FREE;
            q_bank_d[0]         = q_bank_q[1];
            q_mode_d[0]         = q_mode_q[1];
            q_cnt_d             = q_cnt_q - 2'd1;
        end

        if (state_q == FILL) begin
            if (accept) begin
                bank_d[fill_bank_q] = BANK_FILLING;
            end
            if (accept && last) begin
                bank_d[fill_bank_q]   = BANK_FULL;
                q_bank_d[q_cnt_d[0]] = fill_bank_q;
                q_mode_d[q_cnt_d[0]] = frame_mode;
                q_cnt_d               = q_cnt_d + 2'd1;
                if (bank_d[other] == BANK_FREE) begin
                    fill_bank_d   = other;
                    bank_d[other] = BANK_FILLING;
                end else begin
                    state_d = WAIT_BANK;
                end
            end
        end else begin
            if (bank_d[0] == BANK_FREE || bank_d[1] == BANK_FREE) begin
                fill_bank_d         = (bank_d[0] == BANK_FREE) ? 1'b0 : 1'b1;
                bank_d[fill_bank_d] = BANK_FILLING;
                state_d             = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            fill_bank_q <= 1'b0;
            bank_q[0]   <= BANK_FREE;
            bank_q[1]   <= BANK_FREE;
            q_bank_q[0] <= 1'b0;
            q_bank_q[1] <= 1'b0;
            q_mode_q[0] <= 1'b0;
            q_mode_q[1] <= 1'b0;
            q_cnt_q     <= 2'd0;
            mem_we      <= 1'b0;
            mem_bank    <= 1'b0;
            mem_wdata   <= '0;
            drop_cnt    <= 16'd0;
        end else begin
            state_q     <= state_d;
            fill_bank_q <= fill_bank_d;
            bank_q      <= bank_d;
            q_bank_q    <= q_bank_d;
            q_mode_q    <= q_mode_d;
            q_cnt_q     <= q_cnt_d;
            mem_we      <= accept;
            if (accept) begin
                mem_bank  <= fill_bank_q;
                mem_wdata <= s_data;
            end
            if (DROP_ON_FULL && (state_q == WAIT_BANK) && s_valid && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bitrev_frame_loader.sv
// Directed and random checks of two loader instances (stall and drop variants)
// sharing one input stream, against a queue-based behavioural model.
module tb_bitrev_frame_loader;

    localparam int LOG2_N = 3;
    localparam int N      = 8;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              bitrev_en;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              frame_ack;

    logic              a_s_ready, a_mem_we, a_mem_bank, a_frame_valid, a_frame_bank, a_frame_bitrev;
    logic [LOG2_N-1:0] a_mem_addr, a_count;
    logic [DATA_W-1:0] a_mem_wdata;
    logic [15:0]       a_drop_cnt;
    logic              b_s_ready, b_mem_we, b_mem_bank, b_frame_valid, b_frame_bank, b_frame_bitrev;
    logic [LOG2_N-1:0] b_mem_addr, b_count;
    logic [DATA_W-1:0] b_mem_wdata;
    logic [15:0]       b_drop_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_rev [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    bit                m_full [2];
    int                m_fill;
    bit                m_waiting;
    int                m_count;
    bit                m_mode;
    int                m_qbank [$];
    bit                m_qmode [$];
    bit                m_we;
    int                m_wbank;
    int                m_waddr;
    logic [DATA_W-1:0] m_wdata;
    int                m_drop;

    bitrev_frame_loader #(.LOG2_N(LOG2_N), .DATA_W(DATA_W), .DROP_ON_FULL(1'b0)) dut_hold (
        .clk(clk), .rst(rst), .clr(clr), .bitrev_en(bitrev_en), .s_valid(s_valid), .s_data(s_data),
        .s_ready(a_s_ready), .mem_we(a_mem_we), .mem_bank(a_mem_bank), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .frame_valid(a_frame_valid), .frame_bank(a_frame_bank),
        .frame_bitrev(a_frame_bitrev), .frame_ack(frame_ack), .count(a_count), .drop_cnt(a_drop_cnt)
    );

    bitrev_frame_loader #(.LOG2_N(LOG2_N), .DATA_W(DATA_W), .DROP_ON_FULL(1'b1)) dut_drop (
        .clk(clk), .rst(rst), .clr(clr), .bitrev_en(bitrev_en), .s_valid(s_valid), .s_data(s_data),
        .s_ready(b_s_ready), .mem_we(b_mem_we), .mem_bank(b_mem_bank), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .frame_valid(b_frame_valid), .frame_bank(b_frame_bank),
        .frame_bitrev(b_frame_bitrev), .frame_ack(frame_ack), .count(b_count), .drop_cnt(b_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int rev_bits(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOG2_N; i++)
            if (v[i]) r = r | (1 << (LOG2_N - 1 - i));
        return r;
    endfunction

    task automatic modelReset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_fill    = 0;
        m_waiting = 1'b0;
        m_count   = 0;
        m_mode    = 1'b0;
        m_qbank.delete();
        m_qmode.delete();
        m_we      = 1'b0;
        m_wbank   = 0;
        m_waddr   = 0;
        m_wdata   = '0;
        m_drop    = 0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic modelStep();
        int freed;
        bit mode;
        freed = -1;
        m_we  = 1'b0;
        if (frame_ack && m_qbank.size() > 0) begin
            freed = m_qbank.pop_front();
            void'(m_qmode.pop_front());
            m_full[freed] = 1'b0;
        end
        if (m_waiting) begin
            if (s_valid && m_drop < 65535) m_drop++;
            if (!m_full[0] || !m_full[1]) begin
                m_fill    = (freed >= 0) ? freed : (m_full[0] ? 1 : 0);
                m_waiting = 1'b0;
                m_count   = 0;
            end
        end else if (clr) begin
            m_count = 0;
        end else if (s_valid) begin
            mode    = (m_count == 0) ? bitrev_en : m_mode;
            m_mode  = mode;
            m_we    = 1'b1;
            m_wbank = m_fill;
            m_waddr = mode ? rev_bits(m_count) : m_count;
            m_wdata = s_data;
            m_count++;
            if (m_count == N) begin
                m_count        = 0;
                m_full[m_fill] = 1'b1;
                m_qbank.push_back(m_fill);
                m_qmode.push_back(mode);
                if (!m_full[1 - m_fill]) m_fill = 1 - m_fill;
                else m_waiting = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        check("hold.mem_we", a_mem_we, m_we);
        check("drop.mem_we", b_mem_we, m_we);
        if (m_we) begin
            check("hold.mem_bank", a_mem_bank, m_wbank);
            check("drop.mem_bank", b_mem_bank, m_wbank);
            check("hold.mem_addr", a_mem_addr, m_waddr);
            check("drop.mem_addr", b_mem_addr, m_waddr);
            check("hold.mem_wdata", a_mem_wdata, m_wdata);
            check("drop.mem_wdata", b_mem_wdata, m_wdata);
        end
        check("hold.frame_valid", a_frame_valid, m_qbank.size() > 0);
        check("drop.frame_valid", b_frame_valid, m_qbank.size() > 0);
        if (m_qbank.size() > 0) begin
            check("hold.frame_bank", a_frame_bank, m_qbank[0]);
            check("drop.frame_bank", b_frame_bank, m_qbank[0]);
            check("hold.frame_bitrev", a_frame_bitrev, m_qmode[0]);
            check("drop.frame_bitrev", b_frame_bitrev, m_qmode[0]);
        end
        check("hold.count", a_count, m_count);
        check("drop.count", b_count, m_count);
        check("hold.s_ready", a_s_ready, !m_waiting);
        check("drop.s_ready", b_s_ready, 1'b1);
        check("hold.drop_cnt", a_drop_cnt, 16'd0);
        check("drop.drop_cnt", b_drop_cnt, m_drop);
    endtask

    task automatic checkReset();
        check("rst.hold.mem_we", a_mem_we, 1'b0);
        check("rst.drop.mem_we", b_mem_we, 1'b0);
        check("rst.hold.count", a_count, 0);
        check("rst.drop.count", b_count, 0);
        check("rst.hold.frame_valid", a_frame_valid, 1'b0);
        check("rst.drop.frame_valid", b_frame_valid, 1'b0);
        check("rst.hold.frame_bank", a_frame_bank, 1'b0);
        check("rst.hold.frame_bitrev", a_frame_bitrev, 1'b0);
        check("rst.drop.drop_cnt", b_drop_cnt, 16'd0);
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic br,
                                 input logic c, input logic a);
        s_valid   = v;
        s_data    = d;
        bitrev_en = br;
        clr       = c;
        frame_ack = a;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst       = 1'b0;
        clr       = 1'b0;
        bitrev_en = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        frame_ack = 1'b0;
        modelReset();
        #12;
        checkReset();
        rst = 1'b1;

        $display("[TB] bit-reversed frame into bank 0");
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
            check("t1.addr", a_mem_addr, exp_rev[i]);
            check("t1.bank", a_mem_bank, 1'b0);
        end
        check("t1.frame_valid", a_frame_valid, 1'b1);
        check("t1.frame_bank", a_frame_bank, 1'b0);
        check("t1.frame_bitrev", a_frame_bitrev, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

        $display("[TB] natural-order frame, mode toggled mid-frame");
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 16'(i + 100), (i >= 3), 1'b0, 1'b0);
            check("t2.addr", a_mem_addr, i);
            check("t2.bank", a_mem_bank, 1'b1);
        end
        check("t2.frame_bank", a_frame_bank, 1'b1);
        check("t2.frame_bitrev", a_frame_bitrev, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

        $display("[TB] both banks filled, stall and drop");
        for (int i = 0; i < 2 * N; i++) begin
            applyStimulus(1'b1, 16'($urandom), ($urandom_range(1, 0) == 1), 1'b0, 1'b0);
            check("t3.bank", a_mem_bank, (i >= N));
        end
        check("t3.hold_ready_low", a_s_ready, 1'b0);
        check("t3.drop_ready_high", b_s_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
            check("t4.no_write", b_mem_we, 1'b0);
        end
        check("t4.drop_cnt", b_drop_cnt, 16'd5);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        check("t3.ready_back", a_s_ready, 1'b1);
        check("t3.next_frame_bank", a_frame_bank, 1'b1);
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        check("t3.refill_bank", a_mem_bank, 1'b0);

        $display("[TB] clear handling");
        applyStimulus(1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("t5.count_cleared", a_count, 0);
        applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
        check("t5.restart_addr", a_mem_addr, 0);
        applyStimulus(1'b1, 16'h00BB, 1'b0, 1'b1, 1'b0);
        check("t5.clr_blocks_write", a_mem_we, 1'b0);
        check("t5.queued_bank", a_frame_bank, 1'b1);

        $display("[TB] ack coincident with last sample");
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * N - 1; i++)
            applyStimulus(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        check("t6.no_wait", a_s_ready, 1'b1);
        check("t6.frame_bank", a_frame_bank, 1'b1);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("t6.refill_bank", a_mem_bank, 1'b0);
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-frame");
        #2;
        rst = 1'b0;
        #1;
        checkReset();
        @(negedge clk);
        rst = 1'b1;
        modelReset();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(3, 0) != 0), 16'($urandom), ($urandom_range(1, 0) == 1),
                          ($urandom_range(29, 0) == 0), ($urandom_range(5, 0) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
